// File: rtl/mod_addsub_ctrl_pkg.sv
// Shared constants and FSM encoding for the modular add/sub controller.
// Shared with the adder: operand width and adder result width.
package mod_addsub_ctrl_pkg;

    localparam int WIDTH_DEF = 1027;
    localparam int ADD_RES_W = WIDTH_DEF + 1;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        OP1_REQ,
        OP1_WAIT,
        OP2_REQ,
        OP2_WAIT,
        DONE
    } state_t;

endpackage

// File: rtl/mod_addsub_ctrl.sv
// Modular (a+b) mod m / (a-b) mod m driving one shared pipelined adder.
// Define MOD_ADDSUB_TIMEOUT_EN to add a per-op watchdog and an error output.
module mod_addsub_ctrl
    import mod_addsub_ctrl_pkg::*;
#(
`ifdef MOD_ADDSUB_TIMEOUT_EN
    parameter int TIMEOUT = 16,
`endif
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             subtract,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_m,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy,
`ifdef MOD_ADDSUB_TIMEOUT_EN
    output logic             error,
`endif
    output logic             add_start,
    output logic             add_subtract,
    output logic [WIDTH-1:0] add_in_a,
    output logic [WIDTH-1:0] add_in_b,
    input  logic [WIDTH:0]   add_result,
    input  logic             add_done
);

    state_t           state, state_n;
    logic [WIDTH-1:0] a_q, b_q, m_q;
    logic             mode_q;
    logic [WIDTH:0]   t_q;
    logic             timeout;

`ifdef MOD_ADDSUB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
    logic             in_wait;

    assign in_wait = (state == OP1_WAIT) || (state == OP2_WAIT);
    assign timeout = in_wait && !add_done
                   && (cnt_q == CNT_W'(TIMEOUT - 1));
    assign error   = (state == DONE) && err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (state_n != state) begin
            cnt_q <= '0;
        end else if (in_wait) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n      = state;
        add_start    = 1'b0;
        add_subtract = 1'b0;
        add_in_a     = '0;
        add_in_b     = '0;
        done         = (state == DONE);
        busy         = (state != IDLE);
        unique case (state)
            IDLE: begin
                if (start) state_n = OP1_REQ;
            end
            OP1_REQ, OP1_WAIT: begin
                add_start    = (state == OP1_REQ);
                add_subtract = mode_q;
                add_in_a     = a_q;
                add_in_b     = b_q;
                if (state == OP1_REQ) begin
                    state_n = OP1_WAIT;
                end else if (add_done) begin
                    // a-b without borrow is already reduced
                    if (mode_q == MODE_SUB && !add_result[WIDTH])
                        state_n = DONE;
                    else
                        state_n = OP2_REQ;
                end else if (timeout) begin
                    state_n = DONE;
                end
            end
            OP2_REQ, OP2_WAIT: begin
                add_start    = (state == OP2_REQ);
                add_subtract = (mode_q == MODE_ADD);
                add_in_a     = t_q[WIDTH-1:0];
                add_in_b     = m_q;
                if (state == OP2_REQ) state_n = OP2_WAIT;
                else if (add_done || timeout) state_n = DONE;
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q    <= '0;
            b_q    <= '0;
            m_q    <= '0;
            mode_q <= MODE_ADD;
            t_q    <= '0;
            result <= '0;
`ifdef MOD_ADDSUB_TIMEOUT_EN
            err_q  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q    <= in_a;
                        b_q    <= in_b;
                        m_q    <= in_m;
                        mode_q <= subtract;
                    end
`ifdef MOD_ADDSUB_TIMEOUT_EN
                    err_q <= 1'b0;
`endif
                end
                OP1_WAIT: begin
                    if (add_done) begin
                        t_q <= add_result;
                        if (mode_q == MODE_SUB && !add_result[WIDTH])
                            result <= add_result[WIDTH-1:0];
                    end
                end
                OP2_WAIT: begin
                    if (add_done) begin
                        // add: keep T when T-m borrowed and T had no carry
                        if (mode_q == MODE_SUB || t_q[WIDTH]
                            || !add_result[WIDTH])
                            result <= add_result[WIDTH-1:0];
                        else
                            result <= t_q[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
`ifdef MOD_ADDSUB_TIMEOUT_EN
            if (timeout) begin
                result <= '0;
                err_q  <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_mod_addsub_ctrl.sv
// Scoreboard bench for mod_addsub_ctrl with a behavioural adder model.
// Define MOD_ADDSUB_TIMEOUT_EN to also exercise the watchdog.
module tb_mod_addsub_ctrl;
    import mod_addsub_ctrl_pkg::*;

    localparam int W = WIDTH_DEF;

    logic         clk;
    logic         reset;
    logic         start;
    logic         subtract;
    logic [W-1:0] in_a, in_b, in_m;
    logic [W-1:0] result;
    logic         done, busy;
    logic         add_start, add_subtract;
    logic [W-1:0] add_in_a, add_in_b;
    logic [W:0]   add_result;
    logic         add_done;
`ifdef MOD_ADDSUB_TIMEOUT_EN
    logic         error;
`endif

    mod_addsub_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .subtract     (subtract),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_m         (in_m),
        .result       (result),
        .done         (done),
        .busy         (busy),
`ifdef MOD_ADDSUB_TIMEOUT_EN
        .error        (error),
`endif
        .add_start    (add_start),
        .add_subtract (add_subtract),
        .add_in_a     (add_in_a),
        .add_in_b     (add_in_b),
        .add_result   (add_result),
        .add_done     (add_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        int           nops;
        logic         err;
    } exp_t;

    exp_t sbq[$];
    int   total  = 0;
    int   passed = 0;

    task automatic check(input string name, input logic [W:0] got,
                         input logic [W:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got (low128) %h expected (low128) %h",
                      name, got[127:0], exp[127:0]);
    endtask

    // Behavioural adder: result lat cycles after the add_start cycle.
    int lat       = 1;
    bit adder_off = 0;
    logic [W:0] r;

    initial begin
        add_done   = 1'b0;
        add_result = '0;
        forever begin
            @(negedge clk);
            if (add_start && !adder_off) begin
                if (add_subtract)
                    r = {1'b0, add_in_a} - {1'b0, add_in_b};
                else
                    r = {1'b0, add_in_a} + {1'b0, add_in_b};
                repeat (lat) @(posedge clk);
                #1;
                add_done   = 1'b1;
                add_result = r;
                @(posedge clk);
                #1;
                add_done   = 1'b0;
                add_result = '0;
            end
        end
    end

    // Monitor: pops the scoreboard on every done pulse.
    int nst     = 0;
    bit prev_as = 0;
    exp_t e;

    always @(negedge clk) begin
        if (reset) begin
            nst     = 0;
            prev_as = 0;
        end else begin
            if (add_start) begin
                nst++;
                if (prev_as) check("add_start_back_to_back", 1, 0);
            end
            prev_as = add_start;
            if (done) begin
                if (sbq.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    check("result", result, e.res);
                    check("adder_ops", nst, e.nops);
                    check("busy_at_done", busy, 1);
`ifdef MOD_ADDSUB_TIMEOUT_EN
                    check("error_at_done", error, e.err);
`endif
                end
                nst = 0;
            end
        end
    end

    task automatic run_op(input logic sub, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] m,
                          input bit push, input logic [W-1:0] res,
                          input int nops, input logic err);
        int n = 0;
        exp_t x;
        while (busy && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 300) check("wait_idle_bound", 0, 1);
        in_a     = a;
        in_b     = b;
        in_m     = m;
        subtract = sub;
        start    = 1'b1;
        if (push) begin
            x.res  = res;
            x.nops = nops;
            x.err  = err;
            sbq.push_back(x);
        end
        @(posedge clk);
        #1;
        start    = 1'b0;
        in_a     = '1;
        in_b     = '1;
        in_m     = '1;
        subtract = ~sub;
    endtask

    logic [W-1:0] mbig;

    initial begin
        mbig     = '1;
        reset    = 1'b1;
        start    = 1'b0;
        subtract = 1'b0;
        in_a     = '0;
        in_b     = '0;
        in_m     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_add_start", add_start, 0);
        check("rst_result", result, 0);
        check("rst_add_in_a", add_in_a, 0);
        reset = 1'b0;

        lat = 1;
        run_op(MODE_ADD, 7, 9, 13, 1, 3, 2, 0);
        run_op(MODE_ADD, 3, 4, 13, 1, 7, 2, 0);
        run_op(MODE_SUB, 9, 3, 13, 1, 6, 1, 0);
        run_op(MODE_SUB, 3, 9, 13, 1, 7, 2, 0);
        while (busy) begin @(posedge clk); #1; end
        lat = 3;
        run_op(MODE_ADD, mbig - 1, mbig - 1, mbig, 1, mbig - 2, 2, 0);
        run_op(MODE_ADD, 6, 7, 13, 1, 0, 2, 0);
        run_op(MODE_SUB, 5, 5, 13, 1, 0, 1, 0);
        while (busy) begin @(posedge clk); #1; end
        lat = 2;
        run_op(MODE_ADD, 0, 0, 13, 1, 0, 2, 0);
        run_op(MODE_ADD, 12, 0, 13, 1, 12, 2, 0);

        // start pulse while busy must not disturb the op in flight
        while (busy) begin @(posedge clk); #1; end
        lat = 4;
        run_op(MODE_ADD, 2, 5, 13, 1, 7, 2, 0);
        repeat (2) begin @(posedge clk); #1; end
        in_a     = 11;
        in_b     = 11;
        in_m     = 17;
        subtract = 1'b1;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;

        // reset while in OP1_WAIT; the late add_done must be ignored
        while (busy) begin @(posedge clk); #1; end
        lat = 6;
        run_op(MODE_ADD, 4, 4, 13, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_done", done, 0);
        check("abort_busy", busy, 0);
        check("abort_add_start", add_start, 0);
        check("abort_add_sub", add_subtract, 0);
        check("abort_add_in_a", add_in_a, 0);
        check("abort_add_in_b", add_in_b, 0);
        check("abort_result", result, 0);
        repeat (12) begin @(posedge clk); #1; end
        check("late_done_busy", busy, 0);
        check("late_done_result", result, 0);

        lat = 1;
        run_op(MODE_ADD, 1, 1, 13, 1, 2, 2, 0);

`ifdef MOD_ADDSUB_TIMEOUT_EN
        begin
            int k;
            while (busy) begin @(posedge clk); #1; end
            adder_off = 1;
            run_op(MODE_ADD, 1, 2, 13, 1, 0, 1, 1);
            k = 0;
            while (!done && k < 40) begin
                @(posedge clk);
                #1;
                k++;
            end
            check("timeout_latency", k, 17);
            check("timeout_error", error, 1);
            @(posedge clk);
            #1;
            adder_off = 0;
        end
`endif

        begin
            int n = 0;
            while ((sbq.size() != 0 || busy) && n < 300) begin
                @(posedge clk);
                #1;
                n++;
            end
            if (n >= 300) check("drain_bound", 0, 1);
        end
        @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
